wb_regfile: RTL and testbench

Writeback stage and architectural register file for the five-stage ARM pipeline: the consumer of the MEM/WB pipeline register's outputs. It selects writeback data from the ALU result or the load data, extracts load bytes, and commits the result into a 16 x 32 register file. It serves three combinational read ports to decode with same-cycle write bypass, diverts R15 writes to the fetch unit as a PC load, and keeps a retired-write counter for debug.

---
 rtl/wb_regfile.sv | 108 ++++++++++
 tb/tb_wb_regfile.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback select, 16x32 architectural register file with three bypassed read
// ports, R15 writes redirected to fetch as a PC load, and a retired-write counter.

module wb_read_port (
    input  logic [3:0]        addr,
    input  logic [15:0][31:0] regs,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [31:0]       wb_data,
    input  logic [31:0]       pc_plus8,
    output logic [31:0]       data
);
    // R15 always reads as PC+8; a same-cycle write to the address wins over the array.
    always_comb begin
        data = regs[addr];
        if (addr == 4'hF)
            data = pc_plus8;
        else if (wr_en && wr_addr == addr)
            data = wb_data;
    end
endmodule

module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write_enable_in,
    input  logic        mem_to_reg_select_in,
    input  logic        mem_size_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mem_data_in,
    input  logic [3:0]  write_reg_addr_in,
    input  logic [3:0]  rd_addr_a_in,
    input  logic [3:0]  rd_addr_b_in,
    input  logic [3:0]  rd_addr_d_in,
    input  logic [31:0] pc_plus8_in,
    output logic [31:0] rd_data_a_out,
    output logic [31:0] rd_data_b_out,
    output logic [31:0] rd_data_d_out,
    output logic [31:0] wb_data_out,
    output logic        pc_load_out,
    output logic [31:0] pc_load_data_out,
    output logic [31:0] write_count_out
);
    localparam int NUM_PORTS = 3;

    logic [15:0][31:0]          regs;
    logic [31:0]                write_count;
    logic [7:0]                 load_byte;
    logic [NUM_PORTS-1:0][3:0]  rd_addr;
    logic [NUM_PORTS-1:0][31:0] rd_data;

    // Little-endian byte lane picked by the low address bits of the load.
    always_comb begin
        load_byte = mem_data_in[7:0];
        case (alu_result_in[1:0])
            2'd1:    load_byte = mem_data_in[15:8];
            2'd2:    load_byte = mem_data_in[23:16];
            2'd3:    load_byte = mem_data_in[31:24];
            default: load_byte = mem_data_in[7:0];
        endcase
    end

    always_comb begin
        wb_data_out = alu_result_in;
        if (mem_to_reg_select_in)
            wb_data_out = mem_size_in ? {24'h0, load_byte} : mem_data_in;
    end

    assign rd_addr = {rd_addr_d_in, rd_addr_b_in, rd_addr_a_in};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_rd
        wb_read_port u_port (
            .addr     (rd_addr[g]),
            .regs     (regs),
            .wr_en    (reg_write_enable_in),
            .wr_addr  (write_reg_addr_in),
            .wb_data  (wb_data_out),
            .pc_plus8 (pc_plus8_in),
            .data     (rd_data[g])
        );
    end

    assign rd_data_a_out   = rd_data[0];
    assign rd_data_b_out   = rd_data[1];
    assign rd_data_d_out   = rd_data[2];
    assign write_count_out = write_count;

    // Entry 15 is never written; it exists only so the read index stays in range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs             <= '0;
            pc_load_out      <= 1'b0;
            pc_load_data_out <= '0;
            write_count      <= '0;
        end else begin
            pc_load_out <= 1'b0;
            if (reg_write_enable_in) begin
                write_count <= write_count + 32'd1;
                if (write_reg_addr_in == 4'hF) begin
                    pc_load_out      <= 1'b1;
                    pc_load_data_out <= {wb_data_out[31:2], 2'b00};
                end else begin
                    regs[write_reg_addr_in] <= wb_data_out;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized checks of wb_regfile against an array-based reference model.

module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic        we, m2r, msize;
    logic [31:0] alu, mdata, pc8;
    logic [3:0]  waddr, ra, rb, rd;
    logic [31:0] rd_a, rd_b, rd_d, wb, pcd, cnt;
    logic        pcl;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [16];
    logic [31:0] m_cnt, m_pcd;
    logic        m_pcl;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk                  (clk),
        .reset                (reset),
        .reg_write_enable_in  (we),
        .mem_to_reg_select_in (m2r),
        .mem_size_in          (msize),
        .alu_result_in        (alu),
        .mem_data_in          (mdata),
        .write_reg_addr_in    (waddr),
        .rd_addr_a_in         (ra),
        .rd_addr_b_in         (rb),
        .rd_addr_d_in         (rd),
        .pc_plus8_in          (pc8),
        .rd_data_a_out        (rd_a),
        .rd_data_b_out        (rd_b),
        .rd_data_d_out        (rd_d),
        .wb_data_out          (wb),
        .pc_load_out          (pcl),
        .pc_load_data_out     (pcd),
        .write_count_out      (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f_wb();
        logic [31:0] sh;
        if (!m2r) return alu;
        if (!msize) return mdata;
        sh = mdata >> (32'(alu[1:0]) * 8);
        return {24'h0, sh[7:0]};
    endfunction

    function automatic logic [31:0] f_rd(input logic [3:0] a);
        if (a == 4'hF) return pc8;
        if (we && waddr == a) return f_wb();
        return m_regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_cnt = '0;
        m_pcd = '0;
        m_pcl = 1'b0;
    endtask

    task automatic settle_check();
        #1;
        chk("wb_data", wb, f_wb());
        chk("rd_a", rd_a, f_rd(ra));
        chk("rd_b", rd_b, f_rd(rb));
        chk("rd_d", rd_d, f_rd(rd));
    endtask

    task automatic tick();
        logic [31:0] w;
        w = f_wb();
        @(posedge clk);
        m_pcl = 1'b0;
        if (we) begin
            m_cnt = m_cnt + 1;
            if (waddr == 4'hF) begin
                m_pcl = 1'b1;
                m_pcd = w & 32'hFFFF_FFFC;
            end else begin
                m_regs[waddr] = w;
            end
        end
        #1;
        chk("pc_load", 32'(pcl), 32'(m_pcl));
        chk("pc_load_data", pcd, m_pcd);
        chk("write_count", cnt, m_cnt);
    endtask

    task automatic drive(input logic e, input logic [3:0] wa, input logic sel, input logic sz,
                         input logic [31:0] a, input logic [31:0] md);
        @(negedge clk);
        we = e; waddr = wa; m2r = sel; msize = sz; alu = a; mdata = md;
    endtask

    initial begin
        logic [31:0] byte_exp [4];
        byte_exp[0] = 32'hDD; byte_exp[1] = 32'hCC; byte_exp[2] = 32'hBB; byte_exp[3] = 32'hAA;

        reset = 1'b0;
        we = 0; m2r = 0; msize = 0; alu = '0; mdata = '0; pc8 = 32'h8;
        waddr = '0; ra = 4'd3; rb = 4'd0; rd = 4'd14;
        model_clear();
        repeat (2) @(negedge clk);
        settle_check();
        chk("reset_count", cnt, 32'h0);
        chk("reset_pcl", 32'(pcl), 32'h0);
        reset = 1'b1;

        // Reset: R3 write plus a pending R15 pulse, then asynchronous reset mid-cycle
        drive(1, 4'd3, 0, 0, 32'h1234_5678, '0);
        settle_check();
        tick();
        drive(1, 4'd15, 0, 0, 32'h0000_2000, '0);
        tick();
        chk("pcl_before_reset", 32'(pcl), 32'h1);
        #2 reset = 1'b0;
        we = 1'b0;
        #1;
        model_clear();
        chk("r3_after_reset", rd_a, 32'h0);
        chk("count_after_reset", cnt, 32'h0);
        chk("pcl_after_reset", 32'(pcl), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Word write with same-cycle bypass
        ra = 4'd5;
        drive(1, 4'd5, 0, 0, 32'hDEAD_BEEF, '0);
        #1 chk("bypass_a", rd_a, 32'hDEAD_BEEF);
        settle_check();
        tick();
        drive(0, 4'd0, 0, 0, '0, '0);
        #1 chk("r5_after_edge", rd_a, 32'hDEAD_BEEF);
        chk("count_one", cnt, 32'h1);
        tick();

        // Byte loads from each lane
        ra = 4'd1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'd1, 1, 1, 32'(k), 32'hAABB_CCDD);
            settle_check();
            tick();
            drive(0, 4'd0, 0, 0, '0, '0);
            #1 chk("byte_lane", rd_a, byte_exp[k]);
        end

        // R15 write redirects to fetch
        ra = 4'd5; rb = 4'd1;
        drive(1, 4'd15, 0, 0, 32'h0000_1003, '0);
        settle_check();
        tick();
        chk("r15_pcl", 32'(pcl), 32'h1);
        chk("r15_target", pcd, 32'h0000_1000);
        drive(0, 4'd0, 0, 0, '0, '0);
        ra = 4'd15; pc8 = 32'h208;
        #1 chk("read_r15", rd_a, 32'h208);
        settle_check();
        tick();
        chk("r15_pcl_drop", 32'(pcl), 32'h0);

        // Disabled write leaves R7 untouched and does not bypass
        ra = 4'd7;
        drive(0, 4'd7, 0, 0, 32'hFFFF_FFFF, '0);
        #1 chk("no_bypass", rd_a, 32'h0);
        settle_check();
        tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 14)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom);
            pc8 = $urandom;
            ra = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
            settle_check();
            tick();
        end

        // Counter wrap via preload
        drive(0, 4'd0, 0, 0, '0, '0);
        force dut.write_count = 32'hFFFF_FFFF;
        #1 release dut.write_count;
        m_cnt = 32'hFFFF_FFFF;
        #1 chk("count_preload", cnt, 32'hFFFF_FFFF);
        drive(1, 4'd2, 0, 0, 32'h0BAD_F00D, '0);
        settle_check();
        tick();
        chk("count_wrap", cnt, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
